// File: rtl/register_file_16_pkg.sv
// Shared constants for the 16-entry register file: register count, address
// width and the two architecturally special indices (link register and PC).
package register_file_16_pkg;

    localparam int REG_COUNT = 16;
    localparam int ADDR_W    = 4;
    localparam int PC_IDX    = 15;
    localparam int LR_IDX    = 14;

    typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage : register_file_16_pkg

// File: rtl/decoder_4to16.sv
// Write-enable decoder: turns the general write address into a one-hot enable
// vector, never enables the PC slot, and folds the link write into R14.
module decoder_4to16
    import register_file_16_pkg::*;
(
    input  logic                 we_i,
    input  reg_addr_t            wa_i,
    input  logic                 we_lr_i,
    output logic [REG_COUNT-1:0] en_o,
    output logic                 lrGeneralWins_o
);

    // The general port owns R14 whenever it targets it; the link port only
    // supplies R14 data when the general port is writing elsewhere or idle.
    always_comb begin
        en_o = '0;
        if (we_i) begin
            en_o[wa_i] = 1'b1;
        end
        en_o[PC_IDX]    = 1'b0;
        en_o[LR_IDX]    = en_o[LR_IDX] | we_lr_i;
        lrGeneralWins_o = we_i && (wa_i == reg_addr_t'(LR_IDX));
    end

endmodule : decoder_4to16

// File: rtl/mux16.sv
// Parameterised 16-to-1 read multiplexer used by each register-file read port.
module mux16
    import register_file_16_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] in_i [REG_COUNT],
    input  reg_addr_t    sel_i,
    output logic [W-1:0] out_o
);

    assign out_o = in_i[sel_i];

endmodule : mux16

// File: rtl/register_file_16.sv
// Sixteen-entry register file: R0-R14 held in flops, R15 reads return the live
// PC+8, one general write plus one link-register write per clock.
module register_file_16
    import register_file_16_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         WE,
    input  reg_addr_t    WA,
    input  logic [W-1:0] WD,
    input  logic         WE_LR,
    input  logic [W-1:0] LR_DATA,
    input  reg_addr_t    RA1,
    input  reg_addr_t    RA2,
    input  reg_addr_t    RA3,
    input  logic [W-1:0] R15_IN,
    output logic [W-1:0] RD1,
    output logic [W-1:0] RD2,
    output logic [W-1:0] RD3
);

    logic [REG_COUNT-1:0] writeEn;
    logic                 lrGeneralWins;
    logic [W-1:0]         regs_q [PC_IDX];
    logic [W-1:0]         regs_d [PC_IDX];
    logic [W-1:0]         muxIn  [REG_COUNT];

    decoder_4to16 u_decoder (
        .we_i            (WE),
        .wa_i            (WA),
        .we_lr_i         (WE_LR),
        .en_o            (writeEn),
        .lrGeneralWins_o (lrGeneralWins)
    );

    always_comb begin
        for (int i = 0; i < PC_IDX; i++) begin
            regs_d[i] = writeEn[i] ? WD : regs_q[i];
        end
        if (writeEn[LR_IDX] && !lrGeneralWins) begin
            regs_d[LR_IDX] = LR_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < PC_IDX; i++) begin
            if (RESET) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Slot 15 of every read mux carries the current PC+8 instead of storage.
    always_comb begin
        for (int i = 0; i < PC_IDX; i++) begin
            muxIn[i] = regs_q[i];
        end
        muxIn[PC_IDX] = R15_IN;
    end

    mux16 #(.W(W)) u_rd1 (.in_i(muxIn), .sel_i(RA1), .out_o(RD1));
    mux16 #(.W(W)) u_rd2 (.in_i(muxIn), .sel_i(RA2), .out_o(RD2));
    mux16 #(.W(W)) u_rd3 (.in_i(muxIn), .sel_i(RA3), .out_o(RD3));

endmodule : register_file_16
